proc_sequencer: RTL

Multi-cycle control unit for the simple processor datapath: latches a 12-bit instruction on a Run request and steps through T-states, driving the register-file enables, A/G accumulator strobes, external-data select and ALU-op select cycle by cycle. It sits between the instruction source (switches or memory) and the shared bus datapath (16 registers, A, G, ALU, bus mux). It replaces the purely combinational per-function decode with sequenced control, so that add/xor complete through the shared bus.

---
 rtl/proc_sequencer_pkg.sv | 27 ++
 rtl/proc_sequencer_dec4to16.sv | 12 +
 rtl/proc_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/proc_sequencer_pkg.sv
// Shared constants and types for the sequenced processor control unit:
// opcodes, T-state encoding, ALU op codes and datapath widths.
package proc_sequencer_pkg;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;
  localparam int FUNC_W   = 4;
  localparam int INSTR_W  = FUNC_W + 2 * IDX_W;

  localparam logic [FUNC_W-1:0] FN_MV  = 4'h0;
  localparam logic [FUNC_W-1:0] FN_MVI = 4'h1;
  localparam logic [FUNC_W-1:0] FN_NOP = 4'h2;
  localparam logic [FUNC_W-1:0] FN_ADD = 4'h3;
  localparam logic [FUNC_W-1:0] FN_XOR = 4'h4;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_XOR  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

endpackage

// File: rtl/proc_sequencer_dec4to16.sv
// 4-bit register index to 16-bit one-hot enable, all-zero when disabled.
module proc_sequencer_dec4to16
  import proc_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);

  assign o_onehot = i_en ? (NUM_REGS'(1) << i_idx) : '0;

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle sequencer: latches an instruction on Run in IDLE and walks
// T1..T3, decoding datapath strobes from the held IR and current state.
module proc_sequencer
  import proc_sequencer_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic [INSTR_W-1:0]  i_instruction,
  output logic [NUM_REGS-1:0] o_r_in,
  output logic [NUM_REGS-1:0] o_r_out,
  output logic                o_a_in,
  output logic                o_g_in,
  output logic                o_g_out,
  output logic                o_extern,
  output logic [1:0]          o_addxor,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_illegal
);

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_ir;

  logic [FUNC_W-1:0]  w_func;
  logic [IDX_W-1:0]   w_x;
  logic [IDX_W-1:0]   w_y;
  logic               w_rin_en;
  logic               w_rout_en;
  logic [IDX_W-1:0]   w_rout_idx;

  assign w_func = r_ir[11:8];
  assign w_x    = r_ir[7:4];
  assign w_y    = r_ir[3:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_run)
        r_ir <= i_instruction;
    end
  end

  // Only the T-state and IR drive the outputs; the live instruction port is
  // looked at solely when it is captured.
  always_comb begin
    w_next     = r_state;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_idx = w_x;
    o_a_in     = 1'b0;
    o_g_in     = 1'b0;
    o_g_out    = 1'b0;
    o_extern   = 1'b0;
    o_addxor   = ALU_PASS;
    o_done     = 1'b0;
    o_illegal  = 1'b0;
    o_busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (i_run) w_next = S_T1;
      S_T1: begin
        w_next = S_IDLE;
        case (w_func)
          FN_MV: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_y;
            w_rin_en   = 1'b1;
            o_done     = 1'b1;
          end
          FN_MVI: begin
            o_extern = 1'b1;
            w_rin_en = 1'b1;
            o_done   = 1'b1;
          end
          FN_NOP: o_done = 1'b1;
          FN_ADD, FN_XOR: begin
            w_rout_en = 1'b1;
            o_a_in    = 1'b1;
            w_next    = S_T2;
          end
          default: begin
            o_done    = 1'b1;
            o_illegal = 1'b1;
          end
        endcase
      end
      S_T2: begin
        w_rout_en  = 1'b1;
        w_rout_idx = w_y;
        o_g_in     = 1'b1;
        o_addxor   = (w_func == FN_ADD) ? ALU_ADD : ALU_XOR;
        w_next     = S_T3;
      end
      S_T3: begin
        o_g_out  = 1'b1;
        w_rin_en = 1'b1;
        o_done   = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  proc_sequencer_dec4to16 u_dec_rin (
    .i_idx    (w_x),
    .i_en     (w_rin_en),
    .o_onehot (o_r_in)
  );

  proc_sequencer_dec4to16 u_dec_rout (
    .i_idx    (w_rout_idx),
    .i_en     (w_rout_en),
    .o_onehot (o_r_out)
  );

endmodule
